// File: rtl/cpc_mem_responder.sv
`default_nettype none
// ============================================================================
// cpc_mem_responder
// CPU byte / video word arbiter onto one 16-bit req/ack RAM port; video wins.
// Optional ack watchdog when RESP_TIMEOUT_EN is defined.
// Revision: 1.0
// ============================================================================
module cpc_mem_responder #(
    parameter logic [21:0] VID_BASE = 22'h000000,
    parameter int          TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ready,
    input  logic        vid_strobe,
    input  logic [14:0] vid_addr,
    output logic [15:0] vid_dout,
    output logic        vid_ovf,
    output logic        ram_req,
    output logic        ram_we,
    output logic [1:0]  ram_be,
    output logic [21:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [15:0] ram_rdata,
    output logic        err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VID    = 2'd1;
    localparam logic [1:0] S_CPU_RD = 2'd2;
    localparam logic [1:0] S_CPU_WR = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        r_req_d;
    logic        r_cpu_pend;
    logic        r_cpu_is_rd;
    logic [22:0] r_cpu_addr;
    logic [7:0]  r_cpu_din;
    logic        r_vid_pend;
    logic [14:0] r_vid_addr;

    logic [7:0]  r_cpu_dout;
    logic        r_cpu_ready;
    logic [15:0] r_vid_dout;
    logic        r_vid_ovf;
    logic        r_ram_req;
    logic        r_ram_we;
    logic [1:0]  r_ram_be;
    logic [21:0] r_ram_addr;
    logic [15:0] r_ram_wdata;

    logic        w_cpu_edge;
    logic        w_cpu_capture;
    logic        w_vid_drop;
    logic        w_busy;
    logic        w_ack;
    logic        w_abort;
    logic        w_done;
    logic        w_enter_vid;
    logic        w_enter_cpu;
    logic [21:0] w_vid_ram_addr;
    logic [7:0]  w_rd_byte;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("cpc_mem_responder: TIMEOUT must be at least 1");
    end

    // A new CPU access is only accepted while none is outstanding.
    assign w_cpu_edge    = (cpu_rd | cpu_wr) & ~r_req_d;
    assign w_cpu_capture = w_cpu_edge & r_cpu_ready;
    assign w_vid_drop    = vid_strobe & (r_vid_pend | (r_state == S_VID));
    assign w_busy        = (r_state != S_IDLE);
    assign w_ack         = ram_ack & w_busy;
    assign w_done        = w_ack | w_abort;

`ifdef RESP_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] r_tmo;
    logic          r_err;

    assign w_abort = w_busy & ~ram_ack & (r_tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (!w_busy || w_done) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_vid_pend) begin
                    w_state_nxt = S_VID;
                end else if (r_cpu_pend) begin
                    w_state_nxt = r_cpu_is_rd ? S_CPU_RD : S_CPU_WR;
                end
            end
            default: begin
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Output decode
    always_comb begin
        w_enter_vid    = (r_state == S_IDLE) && (w_state_nxt == S_VID);
        w_enter_cpu    = (r_state == S_IDLE) &&
                         ((w_state_nxt == S_CPU_RD) || (w_state_nxt == S_CPU_WR));
        w_vid_ram_addr = VID_BASE + {7'b0, r_vid_addr};
        w_rd_byte      = r_cpu_addr[0] ? ram_rdata[15:8] : ram_rdata[7:0];
    end

    // Request capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_d     <= 1'b0;
            r_cpu_pend  <= 1'b0;
            r_cpu_is_rd <= 1'b0;
            r_cpu_addr  <= '0;
            r_cpu_din   <= '0;
            r_vid_pend  <= 1'b0;
            r_vid_addr  <= '0;
            r_vid_ovf   <= 1'b0;
            r_cpu_ready <= 1'b1;
        end else begin
            r_req_d <= cpu_rd | cpu_wr;

            if (w_enter_cpu) begin
                r_cpu_pend <= 1'b0;
            end else if (w_cpu_capture) begin
                r_cpu_pend  <= 1'b1;
                r_cpu_is_rd <= cpu_rd;
                r_cpu_addr  <= cpu_addr;
                r_cpu_din   <= cpu_din;
            end

            if (w_cpu_capture) begin
                r_cpu_ready <= 1'b0;
            end else if (w_done && ((r_state == S_CPU_RD) || (r_state == S_CPU_WR))) begin
                r_cpu_ready <= 1'b1;
            end

            if (w_enter_vid) begin
                r_vid_pend <= 1'b0;
            end else if (vid_strobe && !w_vid_drop) begin
                r_vid_pend <= 1'b1;
                r_vid_addr <= vid_addr;
            end

            if (w_vid_drop) begin
                r_vid_ovf <= 1'b1;
            end
        end
    end

    // RAM port and returned data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_be    <= 2'b00;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_cpu_dout  <= 8'hFF;
            r_vid_dout  <= 16'h0000;
        end else begin
            if (w_enter_vid) begin
                r_ram_req  <= 1'b1;
                r_ram_we   <= 1'b0;
                r_ram_be   <= 2'b11;
                r_ram_addr <= w_vid_ram_addr;
            end else if (w_enter_cpu) begin
                r_ram_req   <= 1'b1;
                r_ram_we    <= (w_state_nxt == S_CPU_WR);
                r_ram_be    <= r_cpu_addr[0] ? 2'b10 : 2'b01;
                r_ram_addr  <= r_cpu_addr[22:1];
                r_ram_wdata <= {r_cpu_din, r_cpu_din};
            end else if (w_done) begin
                r_ram_req <= 1'b0;
            end

            if (w_ack && (r_state == S_VID)) begin
                r_vid_dout <= ram_rdata;
            end else if (w_abort && (r_state == S_VID)) begin
                r_vid_dout <= 16'hFFFF;
            end

            if (w_ack && (r_state == S_CPU_RD)) begin
                r_cpu_dout <= w_rd_byte;
            end else if (w_abort && (r_state == S_CPU_RD)) begin
                r_cpu_dout <= 8'hFF;
            end
        end
    end

    assign cpu_dout  = r_cpu_dout;
    assign cpu_ready = r_cpu_ready;
    assign vid_dout  = r_vid_dout;
    assign vid_ovf   = r_vid_ovf;
    assign ram_req   = r_ram_req;
    assign ram_we    = r_ram_we;
    assign ram_be    = r_ram_be;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

endmodule
`default_nettype wire
